npn_canon: RTL and testbench
============================

# npn_canon

Sequential NPN canonicalizer for 4-input Boolean functions. Accepts a 16-bit truth table and sweeps all 768 NPN transforms: 24 input permutations × 16 input negations × 2 output negations. Returns the canonical class representative and the first transform that produces it. It is the analysis-side counterpart of the per-class exact MIG netlists: its output selects which stored representative circuit realizes an arbitrary function, and with which input/output wiring.

## Interface

Parameters:
- none; width fixed at 4 inputs / 16-bit truth table

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  truth table offered
- in_ready  out  1  block can accept a truth table
- in_tt  in  16  truth table f; bit m = f(x0..x3) with m = x0 + 2·x1 + 4·x2 + 8·x3
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_canon  out  16  canonical truth table
- out_perm  out  5  permutation index, 0..23
- out_neg  out  4  input negation mask; bit i negates input i
- out_onot  out  1  output negation applied

## Operation

- Transform (p, n, o) maps f to g:
  - g[m] = o ^ f[m'], where bit i of m' = x_{p[i]} ^ n[i] and x_j = bit j of m.
- p[] comes from a fixed table of the 24 permutations of (0,1,2,3) in lexicographic order.
  - Index 0 is (0,1,2,3), identity.
  - Index 18 is (3,0,1,2).
  - Index 23 is (3,2,1,0).
- Canonical form is the numerically minimum g over all 768 transforms.
- Enumeration order:
  - perm index 0..23 is the outer loop; neg 0..15 is the inner loop.
  - Each cycle evaluates one (p, n) pair and both o=0 and o=1 combinationally; o=0 is considered first.
- Tie-break: keep the first transform in enumeration order that reaches the minimum. A candidate replaces the running best only if it is strictly less.
- FSM:
  - IDLE: in_ready=1. On in_valid: latch in_tt, clear the counters, load the running best from the identity transform (o=0), go to SWEEP.
  - SWEEP: evaluate the current (perm, neg) and update the best. Advance neg, carrying into perm. After pair (23, 15), go to DONE.
  - DONE: out_valid=1; outputs hold stable. On out_ready, go to IDLE.
- The input register is captured only in IDLE; in_tt is don't-care otherwise.

## Timing

- Reset values:
  - in_ready=0 while rst is asserted; becomes 1 on the first clock edge after release (state IDLE).
  - out_valid=0; out_canon=16'h0000; out_perm=0; out_neg=0; out_onot=0.
  - Counters are zero.
- Handshake:
  - Input transfer happens on an edge with in_valid & in_ready.
  - Output transfer happens on an edge with out_valid & out_ready.
- Latency: SWEEP lasts exactly 384 cycles. out_valid rises 385 cycles after the accept edge.
- Throughput:
  - in_ready is low from the accept edge until the edge after the output transfer. No overlap between jobs.
  - Minimum job period is 386 cycles.
- out_ready held high before out_valid rises: the transfer happens on the first DONE edge (1 cycle in DONE).
- in_valid asserted during SWEEP or DONE is ignored; it is not queued.
- rst mid-SWEEP or mid-DONE: immediate return to IDLE with reset values; any partial result is discarded.
- Running-best comparison is 16-bit unsigned.

## Structure

- Package npn_pkg holds:
  - the permutation table, 24 entries × 4 × 2-bit;
  - the state enum {IDLE, SWEEP, DONE};
  - constants NPN_PERMS=24, NPN_NEGS=16, NPN_SWEEP=384;
  - the result struct type.
- One sub-module, npn_apply: purely combinational, (f, perm index, neg) → g with o=0. The top derives the o=1 candidate as ~g.
- Top holds the FSM, counters, running best and handshake.

## Test plan

- in_tt=16'h0000 → canon 16'h0000, perm 0, neg 0, onot 0; out_valid exactly 385 cycles after accept.
- in_tt=16'hFFFF → canon 16'h0000, perm 0, neg 0, onot 1.
- in_tt=16'hAAAA (x0) → canon 16'h00FF, perm 18, neg 4'h0, onot 1.
- in_tt=16'h8000 (AND4) → canon 16'h0001, perm 0, neg 4'hF, onot 0.
- Back-to-back jobs with out_ready held low for 10 cycles in DONE:
  - outputs stay stable and in_ready stays 0;
  - second job is accepted only after the output transfer;
  - in_valid pulsed during SWEEP has no effect.
- rst asserted at SWEEP cycle 200:
  - all outputs return to reset values asynchronously;
  - next job 16'hAAAA still yields the correct result.
- Random regression: canon equals a software 768-transform minimum, and applying the reported (perm, neg, onot) to in_tt reproduces out_canon.

Source files
------------

// File: rtl/npn_pkg.sv
// Shared types and constants for the 4-input NPN canonicalizer.
// The permutation table is in lexicographic order; entry bits [2i+1:2i] hold p[i].
package npn_pkg;

    localparam int unsigned NPN_PERMS = 24;
    localparam int unsigned NPN_NEGS  = 16;
    localparam int unsigned NPN_SWEEP = 384;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } npn_state_t;

    typedef struct packed {
        logic [15:0] canon;
        logic [4:0]  perm;
        logic [3:0]  neg;
        logic        onot;
    } npn_result_t;

    function automatic logic [7:0] pk(input logic [1:0] p0, input logic [1:0] p1,
                                      input logic [1:0] p2, input logic [1:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    localparam logic [7:0] NPN_PERM_TAB [NPN_PERMS] = '{
        pk(2'd0, 2'd1, 2'd2, 2'd3), pk(2'd0, 2'd1, 2'd3, 2'd2),
        pk(2'd0, 2'd2, 2'd1, 2'd3), pk(2'd0, 2'd2, 2'd3, 2'd1),
        pk(2'd0, 2'd3, 2'd1, 2'd2), pk(2'd0, 2'd3, 2'd2, 2'd1),
        pk(2'd1, 2'd0, 2'd2, 2'd3), pk(2'd1, 2'd0, 2'd3, 2'd2),
        pk(2'd1, 2'd2, 2'd0, 2'd3), pk(2'd1, 2'd2, 2'd3, 2'd0),
        pk(2'd1, 2'd3, 2'd0, 2'd2), pk(2'd1, 2'd3, 2'd2, 2'd0),
        pk(2'd2, 2'd0, 2'd1, 2'd3), pk(2'd2, 2'd0, 2'd3, 2'd1),
        pk(2'd2, 2'd1, 2'd0, 2'd3), pk(2'd2, 2'd1, 2'd3, 2'd0),
        pk(2'd2, 2'd3, 2'd0, 2'd1), pk(2'd2, 2'd3, 2'd1, 2'd0),
        pk(2'd3, 2'd0, 2'd1, 2'd2), pk(2'd3, 2'd0, 2'd2, 2'd1),
        pk(2'd3, 2'd1, 2'd0, 2'd2), pk(2'd3, 2'd1, 2'd2, 2'd0),
        pk(2'd3, 2'd2, 2'd0, 2'd1), pk(2'd3, 2'd2, 2'd1, 2'd0)
    };

endpackage

// File: rtl/npn_apply.sv
// Combinational NPN transform with output polarity 0:
// g[m] = f[m'] where bit i of m' is x_{p[i]} ^ neg[i].
module npn_apply
    import npn_pkg::*;
(
    input  logic [15:0] f,
    input  logic [4:0]  perm,
    input  logic [3:0]  neg,
    output logic [15:0] g
);

    logic [7:0] ent;
    logic [3:0] x;
    logic [3:0] mp;

    always_comb begin
        ent = NPN_PERM_TAB[0];
        x   = '0;
        mp  = '0;
        g   = '0;
        if (32'(perm) < NPN_PERMS) begin
            ent = NPN_PERM_TAB[perm];
        end
        for (int unsigned m = 0; m < 16; m++) begin
            x = 4'(m);
            for (int unsigned i = 0; i < 4; i++) begin
                mp[i] = x[ent[2*i +: 2]] ^ neg[i];
            end
            g[m] = f[mp];
        end
    end

endmodule

// File: rtl/npn_canon.sv
// Sequential NPN canonicalizer: sweeps one (perm, neg) pair per cycle, both
// output polarities at once, and keeps the first strictly-smallest candidate.
module npn_canon
    import npn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_tt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_canon,
    output logic [4:0]  out_perm,
    output logic [3:0]  out_neg,
    output logic        out_onot
);

    npn_state_t  state;
    npn_state_t  state_next;
    logic        alive;
    logic [15:0] f_q;
    logic [4:0]  perm_q;
    logic [3:0]  neg_q;
    npn_result_t best;
    npn_result_t cand;
    logic [15:0] g;
    logic [15:0] g_n;
    logic        accept;
    logic        last;

    npn_apply u_apply (
        .f    (f_q),
        .perm (perm_q),
        .neg  (neg_q),
        .g    (g)
    );

    assign g_n    = ~g;
    assign accept = in_valid && in_ready;
    // {perm, neg} is perm*16 + neg, so the final pair is the last sweep index.
    assign last   = ({perm_q, neg_q} == 9'(NPN_SWEEP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_next;
            alive <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SWEEP;
            SWEEP:   if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = alive && (state == IDLE);
        out_valid = (state == DONE);
    end

    // o=0 is tried before o=1 so ties resolve to the non-inverted output.
    always_comb begin
        cand = best;
        if (g < cand.canon) begin
            cand = '{canon: g, perm: perm_q, neg: neg_q, onot: 1'b0};
        end
        if (g_n < cand.canon) begin
            cand = '{canon: g_n, perm: perm_q, neg: neg_q, onot: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= '0;
            perm_q <= '0;
            neg_q  <= '0;
            best   <= '0;
        end else begin
            if (state == IDLE && accept) begin
                f_q    <= in_tt;
                perm_q <= '0;
                neg_q  <= '0;
                best   <= '{canon: in_tt, perm: '0, neg: '0, onot: 1'b0};
            end else if (state == SWEEP) begin
                best  <= cand;
                neg_q <= neg_q + 4'd1;
                if (last) begin
                    perm_q <= '0;
                end else if (neg_q == 4'(NPN_NEGS - 1)) begin
                    perm_q <= perm_q + 5'd1;
                end
            end
        end
    end

    assign out_canon = best.canon;
    assign out_perm  = best.perm;
    assign out_neg   = best.neg;
    assign out_onot  = best.onot;

endmodule

// File: tb/tb_npn_canon.sv
// Randomized and directed bench for npn_canon against a brute-force
// 768-transform minimum computed from generated lexicographic permutations.
module tb_npn_canon;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_tt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_canon;
    logic [4:0]  out_perm;
    logic [3:0]  out_neg;
    logic        out_onot;

    int n_checks = 0;
    int n_fail   = 0;
    int perms [24][4];

    npn_canon dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tt     (in_tt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_canon (out_canon),
        .out_perm  (out_perm),
        .out_neg   (out_neg),
        .out_onot  (out_onot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_perms();
        int k = 0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int d = 0; d < 4; d++)
                        if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                            perms[k][0] = a; perms[k][1] = b;
                            perms[k][2] = c; perms[k][3] = d;
                            k++;
                        end
    endtask

    function automatic logic [15:0] xform(input logic [15:0] f, input int pi,
                                          input int n, input int o);
        logic [15:0] g = '0;
        for (int m = 0; m < 16; m++) begin
            int mp = 0;
            for (int i = 0; i < 4; i++)
                if ((((m >> perms[pi][i]) & 1) ^ ((n >> i) & 1)) != 0) mp += (1 << i);
            g[m] = f[mp] ^ o[0];
        end
        return g;
    endfunction

    task automatic model(input logic [15:0] f, output logic [15:0] c,
                         output int bp, output int bn, output int bo);
        c = 16'hFFFF; bp = -1; bn = 0; bo = 0;
        for (int p = 0; p < 24; p++)
            for (int n = 0; n < 16; n++)
                for (int o = 0; o < 2; o++) begin
                    logic [15:0] g = xform(f, p, n, o);
                    if (bp < 0 || g < c) begin
                        c = g; bp = p; bn = n; bo = o;
                    end
                end
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic run_job(input logic [15:0] tt, input int stall,
                           input bit early_ready, input bit pulse);
        logic [15:0] ec;
        int ep, en, eo, cyc;
        model(tt, ec, ep, en, eo);
        wait_ready();
        in_valid = 1'b1;
        in_tt    = tt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_tt    = tt ^ 16'h5A5A;
        cyc = 1;
        if (early_ready) out_ready = 1'b1;
        while (!out_valid && cyc < 1000) begin
            if (pulse && cyc == 100) begin
                in_valid = 1'b1;
                in_tt    = ~tt;
            end else begin
                in_valid = 1'b0;
            end
            if (cyc == 2 || cyc == 200) check_eq("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("out_valid_seen", 32'(out_valid), 32'd1);
        check_eq("latency", 32'(cyc), 32'd385);
        check_eq("canon", 32'(out_canon), 32'(ec));
        check_eq("perm", 32'(out_perm), 32'(ep));
        check_eq("neg", 32'(out_neg), 32'(en));
        check_eq("onot", 32'(out_onot), 32'(eo));
        if (early_ready) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_eq("early_xfer_valid", 32'(out_valid), 32'd0);
            check_eq("early_xfer_ready", 32'(in_ready), 32'd1);
            return;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_canon", 32'(out_canon), 32'(ec));
            check_eq("stall_perm", 32'({out_perm, out_neg, out_onot}), 32'({ep[4:0], en[3:0], eo[0]}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("xfer_valid", 32'(out_valid), 32'd0);
        check_eq("xfer_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        build_perms();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_tt     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", 32'({out_canon, out_perm, out_neg, out_onot}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("first_in_ready", 32'(in_ready), 32'd1);

        run_job(16'h0000, 0, 1'b0, 1'b0);
        run_job(16'hFFFF, 0, 1'b0, 1'b0);
        run_job(16'hAAAA, 0, 1'b1, 1'b0);
        run_job(16'h8000, 10, 1'b0, 1'b0);
        run_job(16'h6996, 10, 1'b0, 1'b1);
        run_job(16'hE8E8, 0, 1'b1, 1'b1);

        // reset in the middle of a sweep
        wait_ready();
        in_valid = 1'b1;
        in_tt    = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (199) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_result", 32'({out_canon, out_perm, out_neg, out_onot}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job(16'hAAAA, 2, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [15:0] tt = 16'($urandom);
            run_job(tt, int'($urandom_range(0, 3)), 1'(r % 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
